// File: rtl/mem_line_responder_pkg.sv
// Shared encodings for the line responder: FSM states, cache line status
// codes and the default timing/geometry constants.
package mem_line_responder_pkg;

    localparam int DEFAULT_WAIT  = 2;
    localparam int DEFAULT_BEATS = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } resp_state_e;

    typedef enum logic [1:0] {
        LINE_INVALID = 2'd0,
        LINE_CLEAN   = 2'd1,
        LINE_DIRTY   = 2'd2
    } line_status_e;

    // Width needed to hold values up to v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mem_line_responder_wait_counter.sv
// Down-counter used to insert idle cycles before each memory access.
// A load takes priority over a tick; the count parks at zero.
module wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Count register: reload on request, otherwise step down toward zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_line_responder.sv
// Cache line transfer responder: accepts one fill or writeback request,
// then walks the line beat by beat against a backing memory with a
// configurable number of idle cycles before each access.
module mem_line_responder
    import mem_line_responder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BEATS  = DEFAULT_BEATS,
    parameter int WAIT   = DEFAULT_WAIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(BEATS)-1:0] beat_idx,
    output logic                     beat_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     done,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int IDX_W      = $clog2(BEATS);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int LINE_BYTES = BEATS * BEAT_BYTES;
    localparam int CNT_W      = clog2_min1(WAIT);
    localparam int WAIT_LD    = (WAIT > 0) ? WAIT - 1 : 0;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BEATS - 1);

    resp_state_e       state;
    logic [ADDR_W-1:0] base_q;
    logic              write_q;
    logic [DATA_W-1:0] rd_q;
    logic              last_beat;
    logic              wc_load;
    logic              wc_tick;
    logic              wc_zero;

    assign last_beat = (beat_idx == LAST_IDX);

    // Reload the countdown whenever a WAIT phase is about to start.
    assign wc_load = ((state == ST_IDLE) && req_valid) ||
                     ((state == ST_RESP) && !last_beat);
    assign wc_tick = (state == ST_WAIT);

    wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (wc_load),
        .load_val (CNT_W'(WAIT_LD)),
        .tick     (wc_tick),
        .zero     (wc_zero)
    );

    // Transfer sequencer; strobes are registered and set on entry to the
    // state that owns them, so they are high for exactly that one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat_idx   <= '0;
            base_q     <= '0;
            write_q    <= 1'b0;
            rd_q       <= '0;
            req_ready  <= 1'b1;
            beat_valid <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
        end else begin
            beat_valid <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        base_q    <= req_addr & LINE_MASK;
                        write_q   <= req_write;
                        beat_idx  <= '0;
                        req_ready <= 1'b0;
                        if (WAIT == 0) begin
                            state  <= ST_ACCESS;
                            mem_en <= 1'b1;
                            mem_we <= req_write;
                        end else begin
                            state  <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wc_zero) begin
                        state  <= ST_ACCESS;
                        mem_en <= 1'b1;
                        mem_we <= write_q;
                    end
                end
                ST_ACCESS: begin
                    state      <= ST_RESP;
                    beat_valid <= 1'b1;
                    done       <= last_beat;
                end
                ST_RESP: begin
                    if (!write_q) begin
                        rd_q <= mem_rdata;
                    end
                    if (last_beat) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        beat_idx <= beat_idx + IDX_W'(1);
                        if (WAIT == 0) begin
                            state  <= ST_ACCESS;
                            mem_en <= 1'b1;
                            mem_we <= write_q;
                        end else begin
                            state  <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The base is line aligned and the offset is below the line size, so
    // the sum never disturbs the base bits.
    assign mem_addr  = mem_en ? (base_q + (ADDR_W'(beat_idx) * ADDR_W'(BEAT_BYTES))) : '0;
    assign mem_wdata = mem_en ? wr_data : '0;

    // Memory read data arrives during RESP; outside it the captured copy holds.
    assign rd_data = ((state == ST_RESP) && !write_q) ? mem_rdata : rd_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: two instances (WAIT=2 and WAIT=0) driven
// by directed and random transfers, checked against a cycle schedule
// computed from the transfer timing rules.
module tb_mem_line_responder;

    logic        clk;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] wr_data    [2];
    logic [0:0]  beat_idx   [2];
    logic        beat_valid [2];
    logic [31:0] rd_data    [2];
    logic        done       [2];
    logic        mem_en     [2];
    logic        mem_we     [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic [31:0] mem_rdata  [2];
    logic [31:0] wb_word    [2][2];
    logic [31:0] exp_rd     [2];
    logic [31:0] salt;

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_line_responder #(
            .DATA_W (32),
            .ADDR_W (32),
            .BEATS  (2),
            .WAIT   ((g == 0) ? 2 : 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .wr_data    (wr_data[g]),
            .beat_idx   (beat_idx[g]),
            .beat_valid (beat_valid[g]),
            .rd_data    (rd_data[g]),
            .done       (done[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory contents: two fixed words, everything else a salted hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hAAAA_0000;
        if (a == 32'h0000_1004) return 32'hBBBB_1111;
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // Read port with one cycle latency; garbage when no read was issued.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i] <= (mem_en[i] && !mem_we[i]) ? mem_word(mem_addr[i]) : 32'hDEAD_BEEF;
        end
    end

    // Cache side presents the writeback word for whichever beat is current.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_data[i] = wb_word[i][beat_idx[i]];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One line transfer. mode 0: req_valid dropped after the handshake;
    // mode 1: req_valid held with churning address/write; mode 2: req_valid
    // raised in the done cycle. For modes 1/2 the next call must use cont=1,
    // which treats the current cycle (after done) as its handshake cycle.
    task automatic xfer(input int sel, input bit wr, input logic [31:0] addr,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input int mode, input bit cont);
        int          w;
        int          last_bv;
        int          total;
        int          acc;
        int          k;
        bit          e_en;
        bit          e_bv;
        logic [31:0] base;
        w       = (sel == 0) ? 2 : 0;
        base    = addr & ~32'h7;
        last_bv = 2 * (2 + w);
        total   = last_bv + 1;
        if (!cont) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready[sel]), 32'd1);
        end
        req_valid[sel]  = 1'b1;
        req_write[sel]  = wr;
        req_addr[sel]   = addr;
        wb_word[sel][0] = w0;
        wb_word[sel][1] = w1;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            e_en = 1'b0;
            e_bv = 1'b0;
            k    = 0;
            for (int b = 0; b < 2; b++) begin
                acc = 1 + w + b * (2 + w);
                if (c == acc)     begin e_en = 1'b1; k = b; end
                if (c == acc + 1) begin e_bv = 1'b1; k = b; end
            end
            chk("mem_en", 32'(mem_en[sel]), 32'(e_en));
            chk("mem_we", 32'(mem_we[sel]), 32'(e_en && wr));
            if (e_en) begin
                chk("mem_addr", mem_addr[sel], base + 32'(4 * k));
                if (wr) chk("mem_wdata", mem_wdata[sel], (k == 0) ? w0 : w1);
            end
            chk("beat_valid", 32'(beat_valid[sel]), 32'(e_bv));
            chk("done", 32'(done[sel]), 32'(c == last_bv));
            chk("req_ready", 32'(req_ready[sel]), 32'(c == total));
            if (e_bv) begin
                chk("beat_idx", 32'(beat_idx[sel]), 32'(k));
                if (!wr) exp_rd[sel] = mem_word(base + 32'(4 * k));
            end
            chk("rd_data", rd_data[sel], exp_rd[sel]);
            if (c < total) begin
                if (mode == 1) begin
                    req_addr[sel]  = $urandom;
                    req_write[sel] = 1'($urandom);
                end else if (mode == 2 && c == last_bv) begin
                    req_valid[sel] = 1'b1;
                    req_addr[sel]  = $urandom;
                    req_write[sel] = 1'($urandom);
                end else begin
                    req_valid[sel] = 1'b0;
                end
            end else if (mode == 0) begin
                req_valid[sel] = 1'b0;
            end
        end
    endtask

    initial begin
        int  mode;
        bit  pend;
        salt = $urandom;
        rst  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i]  = 1'b0;
            req_write[i]  = 1'b0;
            req_addr[i]   = '0;
            wb_word[i][0] = '0;
            wb_word[i][1] = '0;
            exp_rd[i]     = '0;
        end

        // Reset state of both instances
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", 32'(req_ready[i]), 32'd1);
            chk("rst_bv", 32'(beat_valid[i]), 32'd0);
            chk("rst_done", 32'(done[i]), 32'd0);
            chk("rst_en", 32'(mem_en[i]), 32'd0);
            chk("rst_we", 32'(mem_we[i]), 32'd0);
            chk("rst_addr", mem_addr[i], 32'd0);
            chk("rst_wdata", mem_wdata[i], 32'd0);
            chk("rst_rd", rd_data[i], 32'd0);
            chk("rst_idx", 32'(beat_idx[i]), 32'd0);
        end
        rst = 1'b0;

        // Fill with WAIT=2 from inside the line at 0x1000
        xfer(0, 1'b0, 32'h0000_1004, 32'h0, 32'h0, 0, 1'b0);
        // Writeback with WAIT=0
        xfer(1, 1'b1, 32'h0000_2000, 32'h11, 32'h22, 0, 1'b0);
        // req_valid held with churning address through a whole fill
        xfer(0, 1'b0, 32'h0000_3008, 32'h0, 32'h0, 1, 1'b0);
        xfer(0, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 0, 1'b1);
        // Top of the address space
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 1'b0);
        // Fill then writeback with req_valid raised in the done cycle
        xfer(0, 1'b0, $urandom, 32'h0, 32'h0, 2, 1'b0);
        xfer(0, 1'b1, $urandom, $urandom, $urandom, 0, 1'b1);
        xfer(1, 1'b0, $urandom, 32'h0, 32'h0, 2, 1'b0);
        xfer(1, 1'b1, $urandom, $urandom, $urandom, 0, 1'b1);
        xfer(0, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 0, 1'b0);

        // Reset in the first WAIT cycle of a writeback
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_5000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort_pre_en", 32'(mem_en[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        chk("abort_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_rd", rd_data[0], 32'd0);
        chk("abort_rd1", rd_data[1], 32'd0);
        chk("abort_addr", mem_addr[0], 32'd0);
        chk("abort_wdata", mem_wdata[0], 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_we", 32'(mem_we[0]), 32'd0);
            chk("abort_en", 32'(mem_en[0]), 32'd0);
            chk("abort_bv", 32'(beat_valid[0]), 32'd0);
            chk("abort_done", 32'(done[0]), 32'd0);
            chk("abort_idle_ready", 32'(req_ready[0]), 32'd1);
        end

        // Random transfers, chained where the previous one left req_valid up
        for (int s = 0; s < 2; s++) begin
            pend = 1'b0;
            for (int i = 0; i < 10; i++) begin
                mode = (i == 9) ? 0 : int'($urandom_range(0, 2));
                xfer(s, 1'($urandom), $urandom, $urandom, $urandom, mode, pend);
                pend = (mode != 0);
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
